// File: rtl/bus_ctrl_gen2.sv
// bus_ctrl_gen2 - bus-cycle controller between the core requesters and
// memory-mapped targets. A request is latched in IDLE, its target is picked
// from the top address bits, and a SETUP/WAIT/DONE cycle is run against that
// target's ready line with a wait-state timeout. Every output is driven from a
// register that is loaded on the edge entering the state it belongs to. As a
// result, nothing observed on a bus pin depends combinationally on req or ready.
module bus_ctrl_gen2 #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int NUM_TGT = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req,
    input  logic                we,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic                ack,
    output logic                err,
    output logic [DATA_W-1:0]   rdata,
    output logic                busy,
    output logic [7:0]          err_cnt,
    output logic [NUM_TGT-1:0]  cs,
    output logic                rd,
    output logic                wr,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic [DATA_W-1:0]   bus_rdata,
    input  logic [NUM_TGT-1:0]  ready
);

    localparam int SEL_W = $clog2(NUM_TGT);

    // Last wait-counter value before the transfer is declared timed out.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_r;
    logic               we_r;
    logic [SEL_W-1:0]   sel_r;
    logic [7:0]         wait_cnt_r;
    logic [SEL_W-1:0]   req_sel_s;

    // One-hot chip select for a given target index.
    function automatic logic [NUM_TGT-1:0] sel_onehot(input logic [SEL_W-1:0] s);
        logic [NUM_TGT-1:0] v;
        v    = '0;
        v[s] = 1'b1;
        return v;
    endfunction

    // Target index taken from the top address bits of the incoming request.
    assign req_sel_s = addr[ADDR_W-1 -: SEL_W];

    // Transfer sequencer; every output register is loaded on the edge that
    // enters the state it describes so it is valid for that whole state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            we_r       <= 1'b0;
            sel_r      <= '0;
            wait_cnt_r <= 8'd0;
            ack        <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b0;
            cs         <= '0;
            rd         <= 1'b0;
            wr         <= 1'b0;
            rdata      <= '0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            err_cnt    <= 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ack <= 1'b0;
                    err <= 1'b0;
                    if (req) begin
                        we_r      <= we;
                        sel_r     <= req_sel_s;
                        bus_addr  <= addr;
                        bus_wdata <= wdata;
                        cs        <= sel_onehot(req_sel_s);
                        rd        <= ~we;
                        wr        <= we;
                        busy      <= 1'b1;
                        state_r   <= ST_SETUP;
                    end else begin
                        state_r   <= ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    // Target sees the strobes for one cycle before ready counts.
                    wait_cnt_r <= 8'd0;
                    state_r    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (ready[sel_r]) begin
                        if (!we_r) begin
                            rdata <= bus_rdata;
                        end else begin
                            rdata <= rdata;
                        end
                        err     <= 1'b0;
                        ack     <= 1'b1;
                        cs      <= '0;
                        rd      <= 1'b0;
                        wr      <= 1'b0;
                        state_r <= ST_DONE;
                    end else if (wait_cnt_r == WAIT_LAST) begin
                        if (!we_r) begin
                            rdata <= '0;
                        end else begin
                            rdata <= rdata;
                        end
                        if (err_cnt != 8'hFF) begin
                            err_cnt <= err_cnt + 8'd1;
                        end else begin
                            err_cnt <= err_cnt;
                        end
                        err     <= 1'b1;
                        ack     <= 1'b1;
                        cs      <= '0;
                        rd      <= 1'b0;
                        wr      <= 1'b0;
                        state_r <= ST_DONE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 8'd1;
                    end
                end
                ST_DONE: begin
                    ack     <= 1'b0;
                    err     <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    ack     <= 1'b0;
                    err     <= 1'b0;
                    busy    <= 1'b0;
                    cs      <= '0;
                    rd      <= 1'b0;
                    wr      <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_ctrl_gen2.sv
// Self-checking bench for bus_ctrl_gen2. Each transfer is described by its
// ready delay; the expected ack cycle, strobes and results follow directly
// from that delay and the timeout rule, independent of the controller's states.
module tb_bus_ctrl_gen2;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 16;
    localparam int NUM_TGT = 4;
    localparam int TIMEOUT = 15;
    localparam int NEVER   = 255;

    logic               clk;
    logic               reset;
    logic               req;
    logic               we;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  wdata;
    logic               ack;
    logic               err;
    logic [DATA_W-1:0]  rdata;
    logic               busy;
    logic [7:0]         err_cnt;
    logic [NUM_TGT-1:0] cs;
    logic               rd;
    logic               wr;
    logic [ADDR_W-1:0]  bus_addr;
    logic [DATA_W-1:0]  bus_wdata;
    logic [DATA_W-1:0]  bus_rdata;
    logic [NUM_TGT-1:0] ready;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: last returned read data and the timeout count.
    logic [DATA_W-1:0] m_rdata = 16'h0000;
    int                m_err_cnt = 0;

    bus_ctrl_gen2 #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NUM_TGT(NUM_TGT),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .ack      (ack),
        .err      (err),
        .rdata    (rdata),
        .busy     (busy),
        .err_cnt  (err_cnt),
        .cs       (cs),
        .rd       (rd),
        .wr       (wr),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .ready    (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_cycle(input string tag, input bit busy_e, input logic [3:0] cs_e,
                               input bit rd_e, input bit wr_e, input bit ack_e, input bit err_e);
        chk({tag, ".busy"},    64'(busy),    64'(busy_e));
        chk({tag, ".cs"},      64'(cs),      64'(cs_e));
        chk({tag, ".rd"},      64'(rd),      64'(rd_e));
        chk({tag, ".wr"},      64'(wr),      64'(wr_e));
        chk({tag, ".ack"},     64'(ack),     64'(ack_e));
        chk({tag, ".err"},     64'(err),     64'(err_e));
        chk({tag, ".rdata"},   64'(rdata),   64'(m_rdata));
        chk({tag, ".err_cnt"}, 64'(err_cnt), 64'(m_err_cnt));
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            #1;
            req   = 1'b0;
            ready = 4'($urandom);
            @(negedge clk);
            check_cycle("idle", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
            @(posedge clk);
        end
    endtask

    // One transfer whose target raises ready after d wait cycles
    // (d >= TIMEOUT means it never does). abort_k > 0 pulls reset in that cycle.
    task automatic run_txn(input bit t_we, input logic [15:0] t_addr, input logic [15:0] t_wdata,
                           input logic [15:0] t_rdat, input int d, input int abort_k);
        int         sel;
        int         last;
        bit         tmo;
        logic [3:0] cs_e;
        sel  = int'(t_addr[15:14]);
        cs_e = 4'b0001 << sel;
        tmo  = (d >= TIMEOUT);
        last = tmo ? (2 + TIMEOUT) : (3 + d);
        #1;
        req       = 1'b1;
        we        = t_we;
        addr      = t_addr;
        wdata     = t_wdata;
        bus_rdata = 16'($urandom);
        ready     = 4'($urandom);
        @(negedge clk);
        check_cycle("pre", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        for (int k = 1; k <= last; k++) begin
            #1;
            req       = 1'($urandom_range(0, 1));
            we        = 1'($urandom_range(0, 1));
            addr      = 16'($urandom);
            wdata     = 16'($urandom);
            bus_rdata = (k == 2 + d) ? t_rdat : 16'($urandom);
            ready     = 4'($urandom);
            ready[sel] = (k == 1) ? 1'($urandom_range(0, 1)) : (k >= 2 + d);
            if (k == last) begin
                if (tmo) begin
                    if (!t_we) m_rdata = 16'h0000;
                    if (m_err_cnt < 255) m_err_cnt++;
                end else if (!t_we) begin
                    m_rdata = t_rdat;
                end
            end
            @(negedge clk);
            if (k == abort_k) begin
                reset = 1'b0;
                m_rdata   = 16'h0000;
                m_err_cnt = 0;
                #1;
                check_cycle("abort", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
                chk("abort.bus_addr", 64'(bus_addr), 64'd0);
                for (int j = 0; j < 3; j++) begin
                    @(posedge clk);
                    #1;
                    req = 1'b1;
                    @(negedge clk);
                    check_cycle("in_rst", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
                end
                @(posedge clk);
                #1;
                reset = 1'b1;
                return;
            end
            check_cycle("txn", 1'b1, (k < last) ? cs_e : 4'b0000,
                        (k < last) && !t_we, (k < last) && t_we, k == last, (k == last) && tmo);
            chk("txn.bus_addr",  64'(bus_addr),  64'(t_addr));
            chk("txn.bus_wdata", 64'(bus_wdata), 64'(t_wdata));
            @(posedge clk);
        end
    endtask

    initial begin
        reset     = 1'b1;
        req       = 1'b0;
        we        = 1'b0;
        addr      = 16'h0000;
        wdata     = 16'h0000;
        bus_rdata = 16'h0000;
        ready     = 4'b0000;
        #1;
        reset = 1'b0;
        req   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_cycle("reset", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("reset.bus_addr",  64'(bus_addr),  64'd0);
            chk("reset.bus_wdata", 64'(bus_wdata), 64'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Zero-wait read, then wait-state write.
        run_txn(1'b0, 16'h4010, 16'h0000, 16'hBEEF, 0, 0);
        idle_cycles(1);
        run_txn(1'b1, 16'hC000, 16'h1234, 16'h5555, 4, 0);
        idle_cycles(2);

        // Timeout and the ready boundary either side of it.
        run_txn(1'b0, 16'h8abc, 16'h0000, 16'h1111, NEVER, 0);
        run_txn(1'b0, 16'h8123, 16'h0000, 16'h2222, TIMEOUT - 1, 0);
        run_txn(1'b0, 16'h8124, 16'h0000, 16'h3333, TIMEOUT, 0);
        run_txn(1'b0, 16'h0042, 16'h0000, 16'h4444, 1, 0);

        // Back-to-back reads with req kept high.
        run_txn(1'b0, 16'h0123, 16'h0000, 16'hA5A5, 0, 0);
        run_txn(1'b0, 16'hC456, 16'h0000, 16'h5A5A, 0, 0);
        idle_cycles(1);

        // Reset in the second wait cycle of a slow read, then a normal read.
        run_txn(1'b0, 16'h4000, 16'h0000, 16'hAAAA, 10, 3);
        run_txn(1'b0, 16'h4444, 16'h0000, 16'h7777, 2, 0);

        // Error counter saturation.
        for (int i = 0; i < 300; i++) begin
            run_txn(1'($urandom_range(0, 1)), {2'b10, 14'($urandom)}, 16'($urandom),
                    16'($urandom), NEVER, 0);
        end
        chk("sat.err_cnt", 64'(err_cnt), 64'd255);

        // Random mix of targets, directions and delays.
        for (int i = 0; i < 150; i++) begin
            run_txn(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 16'($urandom),
                    $urandom_range(0, TIMEOUT + 2), 0);
            idle_cycles($urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
